dino_jump: RTL and testbench
============================

DINO_JUMP -- requirements
Module: dino_jump

Interface
REQ-001 The block SHALL have parameter V0, default 12, meaning the initial upward velocity in height units per tick.
REQ-002 The block SHALL have parameter HW, default 7, meaning the height width; V0*(V0+1)/2 < 2^HW is a legal-configuration requirement.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; every register is clocked on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port tick_src, input, 1 bit: the divided-clock level from the clock divider, sampled as data and never used as a clock.
REQ-006 The block SHALL have port jump_btn, input, 1 bit: the asynchronous jump button level, high = pressed.
REQ-007 The block SHALL have port pause, input, 1 bit: high freezes jump motion.
REQ-008 The block SHALL have port height, output, HW bits: the dino height above ground, where 0 = on ground.
REQ-009 The block SHALL have port airborne, output, 1 bit: high whenever state != GROUND.
REQ-010 The block SHALL have port land_pulse, output, 1 bit: a one-clk pulse on landing.

Function
REQ-011 The block SHALL pass tick_src through two flops (t1, t2) and form tick = t1 & ~t2, giving exactly one clk-wide tick per tick_src rising edge.
REQ-012 The block SHALL register any tick_src rising edge on the 2nd clk rising edge after that edge.
REQ-013 The block SHALL synchronise jump_btn through two flops to produce btn_s.
REQ-014 The block SHALL implement states GROUND, RISE and FALL, and registers vel (HW bits) and jump_req (1 bit).
REQ-015 The block SHALL define start = (state==GROUND) & tick & ~pause & (jump_req | btn_s).
REQ-016 The block SHALL set jump_req when btn_s=1, state==GROUND and start=0, and SHALL clear jump_req on start.
REQ-017 The block SHALL ignore button presses while airborne: no request is buffered for after landing.
REQ-018 On GROUND with start, the block SHALL set height to V0, set vel to V0-1 and go to RISE.
REQ-019 On GROUND without start, the block SHALL hold height at 0.
REQ-020 On RISE with tick & ~pause and vel==0, the block SHALL go to FALL with height unchanged and vel = 0.
REQ-021 On RISE with tick & ~pause and vel != 0, the block SHALL set height to height+vel and vel to vel-1.
REQ-022 On FALL with tick & ~pause, the block SHALL compute v' = vel+1.
REQ-023 In FALL, if height <= v' the block SHALL set height to 0, set vel to 0, go to GROUND and assert land_pulse for the next clk only.
REQ-024 In FALL, if height > v' the block SHALL set height to height-v' and vel to v'.
REQ-025 Height arithmetic SHALL never wrap: the landing clamp guarantees it never underflows and the REQ-002 constraint guarantees it never overflows.
REQ-026 While pause=1, ticks SHALL be discarded (not deferred), and state, height and vel SHALL hold.
REQ-027 While pause=1, jump_req latching SHALL continue.
REQ-028 On a landing tick, start SHALL NOT be evaluated; a held button gives the next jump on the following tick.
REQ-029 All outputs SHALL be registered; airborne SHALL be decoded from the state register without combinational path from inputs.

Reset
REQ-030 While rst=1 at a clk edge, the block SHALL clear t1, t2, the button synchronisers, jump_req, vel, height and land_pulse to 0, and set state to GROUND, giving airborne=0.
REQ-031 Reset mid-jump SHALL return the block to GROUND with height=0 on the next clk edge, with no land_pulse.
REQ-032 A tick coincident with rst SHALL be discarded.

Verification
REQ-033 The bench SHALL cover a full jump: V0=12, hold btn, one tick, then release -> height sequence 12,23,33,42,50,57,63,68,72,75,77,78, then 78 (enter FALL), then 77,75,72,68,63,57,50,42,33,23,12,0; land_pulse asserts exactly once; 25 ticks total.
REQ-034 The bench SHALL cover a short press: btn pulse of 5 clk between ticks -> jump_req latches, and the next tick starts the jump with height=12.
REQ-035 The bench SHALL cover pause: pause=1 across 3 ticks at height 50 -> height stays 50 and vel is unchanged; after release, the trajectory resumes from 57.
REQ-036 The bench SHALL cover a press while airborne: btn pressed and released during RISE -> no second jump after landing.
REQ-037 The bench SHALL cover held button plus reset: btn held -> a new jump starts on the first tick after land_pulse; rst asserted at height 63 -> next clk height=0, airborne=0, land_pulse=0.
REQ-038 The bench SHALL cover tick edge detection: tick_src held high for 100 clk -> exactly one height update.

Source files
------------

// File: rtl/dino_jump.sv
// rtl/dino_jump.sv - jump physics for the dino: tick-driven rise/fall with integer gravity.
// Tick and button are resynchronised to clk; all motion happens on single-clk tick strobes.
module dino_jump #(
  parameter int V0 = 12,
  parameter int HW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_src,
  input  logic          jump_btn,
  input  logic          pause,
  output logic [HW-1:0] height,
  output logic          airborne,
  output logic          land_pulse
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_t;

  state_t        state, state_n;
  logic          t1, t2, tick;
  logic          btn_m, btn_s;
  logic [HW-1:0] vel, vel_n, vel_inc;
  logic [HW-1:0] height_n;
  logic          jump_req, jump_req_n;
  logic          land_n;
  logic          advance, start;

  // tick_src is a data level from the divider; edge-detect it in the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      t1    <= 1'b0;
      t2    <= 1'b0;
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      t1    <= tick_src;
      t2    <= t1;
      btn_m <= jump_btn;
      btn_s <= btn_m;
    end
  end

  assign tick    = t1 & ~t2;
  assign advance = tick & ~pause;
  assign start   = (state == GROUND) & advance & (jump_req | btn_s);
  assign vel_inc = vel + HW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= GROUND;
      height     <= '0;
      vel        <= '0;
      jump_req   <= 1'b0;
      land_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      height     <= height_n;
      vel        <= vel_n;
      jump_req   <= jump_req_n;
      land_pulse <= land_n;
    end
  end

  always_comb begin
    state_n    = state;
    height_n   = height;
    vel_n      = vel;
    jump_req_n = jump_req;
    land_n     = 1'b0;
    case (state)
      GROUND: begin
        if (start) begin
          height_n   = HW'(V0);
          vel_n      = HW'(V0 - 1);
          jump_req_n = 1'b0;
          state_n    = RISE;
        end else begin
          height_n = '0;
          // Presses are only remembered on the ground, including while paused.
          if (btn_s) jump_req_n = 1'b1;
        end
      end
      RISE: begin
        if (advance) begin
          if (vel == '0) begin
            state_n = FALL;
            vel_n   = '0;
          end else begin
            height_n = height + vel;
            vel_n    = vel - HW'(1);
          end
        end
      end
      FALL: begin
        if (advance) begin
          // Clamp at the ground so the subtraction can never wrap.
          if (height <= vel_inc) begin
            height_n = '0;
            vel_n    = '0;
            state_n  = GROUND;
            land_n   = 1'b1;
          end else begin
            height_n = height - vel_inc;
            vel_n    = vel_inc;
          end
        end
      end
      default: begin
        state_n  = GROUND;
        height_n = '0;
        vel_n    = '0;
      end
    endcase
  end

  assign airborne = (state != GROUND);

endmodule

// File: tb/tb_dino_jump.sv
// tb/tb_dino_jump.sv - directed table-driven bench for dino_jump.
module tb_dino_jump;

  localparam int HW = 7;

  logic          clk = 1'b0;
  logic          rst, tick_src, jump_btn, pause;
  logic [HW-1:0] height;
  logic          airborne, land_pulse;

  always #5 clk = ~clk;

  dino_jump #(.V0(12), .HW(HW)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_src  (tick_src),
    .jump_btn  (jump_btn),
    .pause     (pause),
    .height    (height),
    .airborne  (airborne),
    .land_pulse(land_pulse)
  );

  typedef struct {
    logic          btn;
    logic          pse;
    logic [HW-1:0] h;
    logic          air;
    logic          land;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   traj[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic b, input logic p, input int h, input logic a, input logic l);
    vec_t v;
    v.btn  = b;
    v.pse  = p;
    v.h    = HW'(h);
    v.air  = a;
    v.land = l;
    vecs.push_back(v);
  endfunction

  // One tick_src pulse; returns at the negedge where the resulting update (and land_pulse) is visible.
  task automatic do_tick();
    @(negedge clk) tick_src = 1'b1;
    @(negedge clk) tick_src = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int changes;
    logic [HW-1:0] prev;

    traj = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78,
             77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};

    // full jump, then an idle tick
    for (int i = 0; i < 25; i++) add(i == 0, 1'b0, traj[i], i != 24, i == 24);
    add(1'b0, 1'b0, 0, 1'b0, 1'b0);
    // second jump: pause at 50 for three ticks, press during RISE, no rejump after landing
    for (int i = 0; i < 5; i++) add(i == 0, 1'b0, traj[i], 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 50, 1'b1, 1'b0);
    for (int i = 5; i < 25; i++) add(i == 6 || i == 7, 1'b0, traj[i], i != 24, i == 24);
    add(1'b0, 1'b0, 0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 0, 1'b0, 1'b0);

    rst = 1'b1; tick_src = 1'b0; jump_btn = 1'b0; pause = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_height", 32'(height), 0);
    check("reset_airborne", 32'(airborne), 0);
    check("reset_land", 32'(land_pulse), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      jump_btn = vecs[i].btn;
      pause    = vecs[i].pse;
      repeat (2) @(negedge clk);
      do_tick();
      check($sformatf("vec%0d_height", i), 32'(height), 32'(vecs[i].h));
      check($sformatf("vec%0d_airborne", i), 32'(airborne), 32'(vecs[i].air));
      check($sformatf("vec%0d_land", i), 32'(land_pulse), 32'(vecs[i].land));
    end
    pause = 1'b0;

    // short press between ticks latches a request
    @(negedge clk) jump_btn = 1'b1;
    repeat (5) @(negedge clk);
    jump_btn = 1'b0;
    repeat (4) @(negedge clk);
    check("short_press_wait_height", 32'(height), 0);
    check("short_press_wait_air", 32'(airborne), 0);
    do_tick();
    check("short_press_height", 32'(height), 12);
    check("short_press_air", 32'(airborne), 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("short_press_rst_height", 32'(height), 0);

    // held button: full jump, next tick after landing restarts, reset at 63
    @(negedge clk) jump_btn = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 25; i++) begin
      do_tick();
      check($sformatf("held%0d_height", i), 32'(height), 32'(traj[i]));
      check($sformatf("held%0d_land", i), 32'(land_pulse), 32'(i == 24));
    end
    do_tick();
    check("held_rejump_height", 32'(height), 12);
    check("held_rejump_air", 32'(airborne), 1);
    for (int i = 1; i <= 6; i++) do_tick();
    check("held_pre_rst_height", 32'(height), 63);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("mid_rst_height", 32'(height), 0);
    check("mid_rst_air", 32'(airborne), 0);
    check("mid_rst_land", 32'(land_pulse), 0);
    rst = 1'b0;
    jump_btn = 1'b0;
    repeat (4) @(negedge clk);

    // long tick_src level gives exactly one update
    @(negedge clk) jump_btn = 1'b1;
    repeat (2) @(negedge clk);
    do_tick();
    jump_btn = 1'b0;
    check("edge_start_height", 32'(height), 12);
    @(negedge clk) tick_src = 1'b1;
    changes = 0;
    prev = height;
    repeat (100) begin
      @(negedge clk);
      if (height != prev) changes++;
      prev = height;
    end
    tick_src = 1'b0;
    repeat (3) @(negedge clk);
    check("edge_updates", 32'(changes), 1);
    check("edge_height", 32'(height), 23);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
